// File: rtl/match_collector_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// match_collector_if : match-vector input and position-output handshake bundle
// rev 1.0
// ----------------------------------------------------------------------------
interface match_collector_if #(
  parameter int CHUNK_W = 16,
  parameter int CNT_W   = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [16:0]          in_match;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [CHUNK_W+3:0]   out_pos;
  logic [CNT_W-1:0]     match_count;
  logic                 done;

  modport slave (
    input  in_valid, in_match, in_last, out_ready,
    output in_ready, out_valid, out_pos, match_count, done
  );

  modport master (
    output in_valid, in_match, in_last, out_ready,
    input  in_ready, out_valid, out_pos, match_count, done
  );
endinterface
`default_nettype wire

// File: rtl/match_collector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// match_collector : serialises per-chunk match flags into ascending positions
// rev 1.0
// ----------------------------------------------------------------------------
module match_collector #(
  parameter int CHUNK_W = 16,
  parameter int CNT_W   = 16
) (
  input  wire logic          clk,
  input  wire logic          reset,
  match_collector_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]          state;
  logic [CHUNK_W-1:0]  chunk;
  logic [16:0]         pending;
  logic                last_q;
  logic [CNT_W-1:0]    count;

  logic                in_xfer;
  logic                out_xfer;
  logic [16:0]         mask;
  logic [4:0]          low_idx;
  logic [16:0]         pending_next;
  logic [CNT_W-1:0]    count_inc;

  assign in_xfer  = bus.in_valid && (state == S_IDLE);
  assign out_xfer = bus.out_ready && (state == S_DRAIN);

  // Bit 16 aliases the next chunk's bit 0, so it only counts on the final chunk.
  assign mask = bus.in_last ? bus.in_match : {1'b0, bus.in_match[15:0]};

  always_comb begin
    low_idx = 5'd0;
    for (int k = 16; k >= 0; k--) begin
      if (pending[k]) begin
        low_idx = 5'(k);
      end
    end
  end

  assign pending_next = pending & (pending - 17'd1);
  assign count_inc    = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      chunk   <= '0;
      pending <= '0;
      last_q  <= 1'b0;
      count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_xfer) begin
            if (mask == 17'd0) begin
              if (bus.in_last) begin
                state <= S_DONE;
              end else begin
                chunk <= chunk + CHUNK_W'(1);
              end
            end else begin
              pending <= mask;
              last_q  <= bus.in_last;
              state   <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (out_xfer) begin
            pending <= pending_next;
            count   <= count_inc;
            if (pending_next == 17'd0) begin
              if (last_q) begin
                state <= S_DONE;
              end else begin
                chunk <= chunk + CHUNK_W'(1);
                state <= S_IDLE;
              end
            end
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          chunk   <= '0;
          pending <= '0;
          last_q  <= 1'b0;
          count   <= '0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = (state == S_IDLE);
  assign bus.out_valid   = (state == S_DRAIN);
  assign bus.done        = (state == S_DONE);
  assign bus.match_count = count;
  // Position is purely a function of registered state, so it holds during stalls.
  assign bus.out_pos     = {chunk, 4'b0000} + (CHUNK_W + 4)'(low_idx);

endmodule
`default_nettype wire

// File: tb/tb_match_collector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_match_collector : randomized scoreboard bench for match_collector
// rev 1.0
// ----------------------------------------------------------------------------
module tb_match_collector;

  localparam int CHUNK_W = 4;
  localparam int CNT_W   = 16;
  localparam int POS_W   = CHUNK_W + 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  match_collector_if #(.CHUNK_W(CHUNK_W), .CNT_W(CNT_W)) bus ();
  match_collector_if #(.CHUNK_W(CHUNK_W), .CNT_W(2))     bus2 ();

  match_collector #(.CHUNK_W(CHUNK_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Narrow-counter copy shares all stimulus; only its count is checked.
  match_collector #(.CHUNK_W(CHUNK_W), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_match  = bus.in_match;
  assign bus2.in_last   = bus.in_last;
  assign bus2.out_ready = bus.out_ready;

  int checks   = 0;
  int failures = 0;
  int exp_pos[$];
  int exp_cnt[$];
  int model_chunk = 0;
  int model_count = 0;
  int rdy_mode    = 0;
  int xfer_cnt    = 0;
  bit done_prev   = 1'b0;
  bit stall_prev  = 1'b0;
  int stall_pos   = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: drives out_ready, then samples the settled outputs.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (reset) begin
        done_prev  = 1'b0;
        stall_prev = 1'b0;
      end else begin
        if (bus.out_valid) check("in_ready_in_drain", int'(bus.in_ready), 0);
        if (stall_prev && bus.out_valid) check("pos_stable", int'(bus.out_pos), stall_pos);
        stall_prev = bus.out_valid && !bus.out_ready;
        stall_pos  = int'(bus.out_pos);
        if (bus.out_valid && bus.out_ready) begin
          xfer_cnt++;
          if (exp_pos.size() == 0) check("unexpected_pos", int'(bus.out_valid), 0);
          else check("out_pos", int'(bus.out_pos), exp_pos.pop_front());
        end
        if (bus.done) begin
          int e;
          check("done_single", int'(done_prev), 0);
          check("pos_left_at_done", exp_pos.size(), 0);
          if (exp_cnt.size() == 0) begin
            check("unexpected_done", int'(bus.done), 0);
          end else begin
            e = exp_cnt.pop_front();
            check("match_count", int'(bus.match_count), e);
            check("sat_count", int'(bus2.match_count), (e > 3) ? 3 : e);
          end
        end
        done_prev = bus.done;
      end
    end
  end

  task automatic send_chunk(input logic [16:0] m, input bit last);
    logic [16:0] mask;
    int budget;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_match = 17'($urandom);
      bus.in_last  = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_match = m;
    bus.in_last  = last;
    budget = 0;
    while (!bus.in_ready && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 300) check("in_ready_timeout", int'(bus.in_ready), 1);
    mask = last ? m : {1'b0, m[15:0]};
    for (int k = 0; k < 17; k++)
      if (mask[k]) exp_pos.push_back((model_chunk * 16 + k) % (1 << POS_W));
    model_count = model_count + $countones(mask);
    if (model_count > 65535) model_count = 65535;
    if (last) begin
      exp_cnt.push_back(model_count);
      model_chunk = 0;
      model_count = 0;
    end else begin
      model_chunk = (model_chunk + 1) % (1 << CHUNK_W);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #3;
    if (mask != 17'd0) check("first_valid_latency", int'(bus.out_valid), 1);
    else if (last)     check("empty_done_latency", int'(bus.done), 1);
  endtask

  task automatic wait_done();
    int budget;
    budget = 0;
    while ((exp_pos.size() != 0 || exp_cnt.size() != 0) && budget < 600) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      budget++;
    end
    if (budget >= 600) check("drain_timeout", exp_pos.size() + exp_cnt.size(), 0);
  endtask

  // Reset with a live input handshake offered, which must be ignored.
  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_match = 17'($urandom) | 17'd1;
    bus.in_last  = 1'b1;
    exp_pos.delete();
    exp_cnt.delete();
    model_chunk = 0;
    model_count = 0;
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    #2;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_count", int'(bus.match_count), 0);
    check("rst_count_sat", int'(bus2.match_count), 0);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int base;
    int budget;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_match = '0;
    bus.in_last  = 1'b0;
    repeat (2) @(negedge clk);
    rdy_mode = 0;
    do_reset();

    send_chunk(17'h00000, 1'b0);
    send_chunk(17'h00000, 1'b0);
    send_chunk(17'h00005, 1'b1);
    wait_done();

    send_chunk(17'h10001, 1'b0);
    send_chunk(17'h10000, 1'b1);
    wait_done();

    rdy_mode = 1;
    send_chunk(17'h0FFFF, 1'b1);
    wait_done();

    rdy_mode = 0;
    send_chunk(17'h00000, 1'b1);
    wait_done();

    // Abort a stream part-way through its drain.
    base = xfer_cnt;
    send_chunk(17'h000FF, 1'b1);
    budget = 0;
    while (xfer_cnt < base + 3 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) check("partial_drain_timeout", xfer_cnt - base, 3);
    do_reset();
    repeat (4) @(negedge clk);
    send_chunk(17'h00001, 1'b1);
    wait_done();

    send_chunk(17'h0001F, 1'b1);
    wait_done();

    // Long stream so the chunk counter wraps.
    rdy_mode = 2;
    for (int i = 0; i < 18; i++)
      send_chunk(17'($urandom & $urandom & $urandom), (i == 17));
    wait_done();

    for (int s = 0; s < 15; s++) begin
      int len;
      rdy_mode = $urandom_range(0, 2);
      len = $urandom_range(1, 5);
      for (int c = 0; c < len; c++)
        send_chunk(17'($urandom & $urandom), (c == len - 1));
      wait_done();
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/match_collector.md
MATCH_COLLECTOR -- requirements
Module: match_collector

Interface
REQ-001 Parameter CHUNK_W, default 16: chunk index counter width.
REQ-002 Parameter CNT_W, default 16: match counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  match vector valid.
REQ-006 in_ready  output  1  block accepts vector this cycle.
REQ-007 in_match  input  17  per-offset match flags from the 17-window matcher; bit k = pattern hit at offset k of the current 16-position chunk.
REQ-008 in_last  input  1  qualifies in_match as final chunk of the stream.
REQ-009 out_valid  output  1  reported position valid.
REQ-010 out_ready  input  1  consumer accepts position.
REQ-011 out_pos  output  CHUNK_W+4  absolute match position = chunk*16 + offset.
REQ-012 match_count  output  CNT_W  matches reported in current stream.
REQ-013 done  output  1  one-cycle pulse, stream fully reported.

Function
REQ-014 FSM states IDLE, DRAIN, DONE; reset state IDLE.
REQ-015 Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
REQ-016 in_ready = 1 only in IDLE; out_valid = 1 only in DRAIN; done = 1 only in DONE.
REQ-017 Accepted mask = in_match[15:0] when in_last = 0; mask = in_match[16:0] when in_last = 1 (bit 16 duplicates next chunk's bit 0, counted only on last chunk).
REQ-018 IDLE, accept, mask = 0: in_last=0 -> chunk += 1, stay IDLE; in_last=1 -> DONE.
REQ-019 IDLE, accept, mask != 0: pending <= mask, last_q <= in_last, -> DRAIN next cycle.
REQ-020 DRAIN: out_pos = {chunk, 4'b0} + index of lowest set pending bit (bit 16 -> +16); value combinational from registered state, stable while out_valid && !out_ready.
REQ-021 DRAIN, output transfer: clear lowest set pending bit; match_count += 1, saturating at 2^CNT_W-1.
REQ-022 DRAIN, transfer clears final pending bit: last_q=0 -> chunk += 1, -> IDLE; last_q=1 -> DONE.
REQ-023 Positions emitted strictly ascending; one position per transfer; zero bubbles between positions of one chunk.
REQ-024 Latency: first out_valid 1 cycle after the accepting edge; DONE entered the cycle after the last transfer (or after accepting an empty last chunk).
REQ-025 DONE lasts exactly one cycle: done = 1, match_count holds final value; next cycle -> IDLE with chunk = 0, match_count = 0.
REQ-026 Chunk counter wraps modulo 2^CHUNK_W without error.
REQ-027 in_match and in_last ignored when no input transfer occurs.
REQ-028 out_ready ignored outside DRAIN.

Reset
REQ-029 reset asserted at a rising edge, from any state including mid-DRAIN: next cycle state = IDLE, chunk = 0, pending = 0, last_q = 0, match_count = 0, out_valid = 0, done = 0, in_ready = 1.
REQ-030 Pending positions at reset are discarded, never emitted.
REQ-031 reset has priority over all simultaneous handshakes.

Verification
REQ-032 Chunks 0x0000,0x0000 (in_last=0), then in_match=17'h00005 in_last=1, out_ready=1 -> out_pos 32, 34; match_count=2 at done; done pulses once.
REQ-033 in_match=17'h10001 in_last=0 then 17'h10000 in_last=1 -> out_pos 0 (bit16 of chunk 0 dropped), then 32; match_count=2.
REQ-034 in_match=17'h0FFFF in_last=1, out_ready toggled 1/0 -> 16 positions 0..15 ascending, out_pos stable during stalls, in_ready=0 throughout DRAIN.
REQ-035 Single empty chunk in_match=0, in_last=1 -> no out_valid, done one cycle after accept, match_count=0.
REQ-036 reset asserted after 3 of 8 positions transferred -> remaining 5 never appear; next stream starts at chunk 0, match_count 0.
REQ-037 CNT_W=2 override, 5 matches in one stream -> match_count saturates at 3.
